mem_test_master: RTL and testbench
==================================

Name: mem_test_master

Overview:
- Synthesizable 68030-style bus initiator; drives the same async-strobe bus that the block-RAM bridge answers, and replaces the CPU for memory bring-up.
- On start it writes NUM_WORDS longwords of a deterministic pattern from BASE_ADDR, then reads them back and compares.
- It ends with one signature write: ADR_OUT[31:16]=16'h00aa on pass, 16'h00ff plus an error code on fail.
- It sits in the context top in place of virtual_top's CPU bus outputs and connects directly to blockram_030_bridge_tb.

Parameters:
- BASE_ADDR, 32'h0000_1000, byte address of first longword; must be 4-aligned.
- NUM_WORDS, 64, longwords tested; range 1..32768.
- TIMEOUT_CYCLES, 255, clk cycles to wait for DTACK assert or negate before error.
- SETUP_CYCLES, 1, cycles address/RWn/data are stable before ASn falls; range 1..15.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle pulse that begins a test; ignored unless idle.
- ADR_OUT  out  32  byte address.
- DATA_OUT  out  32  write data.
- DATA_IN  in  32  read data, sampled on the DTACK edge.
- ASn  out  1  address strobe, active low.
- RWn  out  1  1=read, 0=write.
- UDS, LDS, UDS2, LDS2  out  1 each  active-high byte-lane enables for D31:24, D23:16, D15:8, D7:0.
- DBENn  out  1  data buffer enable, active low, asserted with ASn.
- DTACK  in  1  active-high responder acknowledge.
- busy  out  1  high from accepted start until done.
- done  out  1  sticky high after the signature cycle completes; cleared by the next accepted start.
- pass  out  1  valid when done; 1 means no error.
- err_code  out  16  0 on pass, otherwise the code defined under Behaviour.

Behaviour:
- Reset (synchronous, active low, checked every edge):
  - Outputs: ASn=1, DBENn=1, RWn=1, all lanes 0, ADR_OUT=0, DATA_OUT=0, busy=0, done=0, pass=0, err_code=0; state IDLE.
  - Reset mid-cycle forces ASn high on the next edge regardless of DTACK.
- Pattern for word i: {~i[15:0], i[15:0]}. Address of word i = BASE_ADDR + 4*i, using 32-bit wrap arithmetic.
- States:
  - IDLE -> SETUP on start. Sets phase=WRITE, i=0, busy=1, clears done.
  - SETUP: drive ADR_OUT and RWn; for writes also drive DATA_OUT. Hold SETUP_CYCLES cycles, then go to STROBE.
  - STROBE: ASn=0, DBENn=0, all four lanes=1. Wait for DTACK=1.
    - On DTACK: a read latches DATA_IN; go to RELEASE.
    - If the timeout counter reaches TIMEOUT_CYCLES first, go to FAIL with code 16'h0001 (write) or 16'h0002 (read).
    - If DTACK and the timeout occur in the same cycle, DTACK wins.
  - RELEASE: ASn=1, DBENn=1, lanes=0; address held. Wait for DTACK=0, with a new timeout, code 16'h0003. Then:
    - write phase, i<NUM_WORDS-1: i++, go to SETUP.
    - write phase, last word: phase=READ, i=0, go to SETUP.
    - read phase: go to CHECK.
  - CHECK (1 cycle): compare the latched data to the pattern.
    - Mismatch -> FAIL with code 16'h8000|i[14:0].
    - Match and not last -> i++, go to SETUP.
    - Match on last word -> PASS.
  - PASS / FAIL: issue one write cycle through the same SETUP/STROBE/RELEASE handshake.
    - Address {16'h00aa, 16'h0000} for PASS, {16'h00ff, err_code} for FAIL; DATA_OUT=0.
    - A timeout during the signature cycle is abandoned silently; the bus is released.
  - DONE: busy=0, done=1, pass set. Go to IDLE.
- Timeout counter: 8 bits minimum, ceil(log2(TIMEOUT_CYCLES+1)) bits; cleared on entry to STROBE and RELEASE.
- Read compare is full 32-bit; the first mismatch terminates the test.
- Bus cycle length at minimum: SETUP_CYCLES + 1 + DTACK latency + 1 + release latency.

Decomposition:
- Package mem_test_pkg: state encoding, ERR_WR_TIMEOUT=16'h0001, ERR_RD_TIMEOUT=16'h0002, ERR_REL_TIMEOUT=16'h0003, ERR_MISMATCH_BASE=16'h8000, SIG_PASS=16'h00aa, SIG_FAIL=16'h00ff, pattern function.
- Sub-module mem_test_bus_cycle: single-cycle engine covering SETUP/STROBE/RELEASE, the timeout counter and the read latch.
  - Interface: req, rw, addr, wdata; ack, timeout, rdata.
- The top level holds the sequencing FSM, index counter and compare.

Test Plan:
- Bridge model with 2-cycle DTACK, NUM_WORDS=4, BASE_ADDR=32'h1000, start:
  - writes 1000..100C with data ffff0000, fffe0001, fffd0002, fffc0003;
  - reads the same addresses; signature address 00aa0000; done=1, pass=1, err_code=0.
- Responder flips bit 0 on the read of word 2 -> signature address 00ff8002; pass=0; err_code=16'h8002.
- DTACK never asserted, TIMEOUT_CYCLES=10 -> ASn low for exactly 10 cycles, then high; err_code=0001; done=1 after the signature attempt.
- DTACK stuck high after the first ack -> err_code=0003.
- Assert reset_n=0 during STROBE of word 1 -> ASn=1 and busy=0 after the next edge; a new start reruns from word 0.
- Second start pulse while busy -> ignored, sequence unchanged; DTACK asserted on the exact timeout cycle -> treated as ack, no error.

Source files
------------

// File: rtl/mem_test_pkg.sv
// Shared definitions for the memory bring-up bus initiator.
// Holds FSM encodings, error/signature codes and the test-pattern function.
package mem_test_pkg;

    // Sequencer states (top level).
    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StCheck,
        StSigIssue,
        StSigWait,
        StDone
    } top_state_e;

    // Single bus-cycle engine states.
    typedef enum logic [1:0] {
        BsIdle,
        BsSetup,
        BsStrobe,
        BsRelease
    } bus_state_e;

    typedef enum logic {
        PhWrite,
        PhRead
    } phase_e;

    localparam logic [15:0] ERR_WR_TIMEOUT    = 16'h0001;
    localparam logic [15:0] ERR_RD_TIMEOUT    = 16'h0002;
    localparam logic [15:0] ERR_REL_TIMEOUT   = 16'h0003;
    localparam logic [15:0] ERR_MISMATCH_BASE = 16'h8000;
    localparam logic [15:0] SIG_PASS          = 16'h00aa;
    localparam logic [15:0] SIG_FAIL          = 16'h00ff;

    // Word i carries {~i, i} so stuck or swapped data lines show up quickly.
    function automatic logic [31:0] pattern(input logic [15:0] idx);
        return {~idx, idx};
    endfunction

endpackage

// File: rtl/mem_test_master_if.sv
// 68030-style async-strobe bus between the test master and a memory responder.
// master: drives address/data/strobes/lanes, receives read data and DTACK.
// slave:  the responder side.
interface mem_test_master_if;
    logic [31:0] ADR_OUT;
    logic [31:0] DATA_OUT;
    logic [31:0] DATA_IN;
    logic        ASn;
    logic        RWn;
    logic        UDS;
    logic        LDS;
    logic        UDS2;
    logic        LDS2;
    logic        DBENn;
    logic        DTACK;

    modport master (
        output ADR_OUT, DATA_OUT, ASn, RWn, UDS, LDS, UDS2, LDS2, DBENn,
        input  DATA_IN, DTACK
    );

    modport slave (
        input  ADR_OUT, DATA_OUT, ASn, RWn, UDS, LDS, UDS2, LDS2, DBENn,
        output DATA_IN, DTACK
    );
endinterface

// File: rtl/mem_test_bus_cycle.sv
// Runs one bus cycle: SETUP (address/RWn/data stable) -> STROBE (wait DTACK)
// -> RELEASE (wait DTACK negate), each wait bounded by TIMEOUT_CYCLES.
// Ports: clk, reset_n; req/rw(1=read)/addr/wdata request, sampled while idle;
// ack pulses when the cycle completes, timeout pulses on an expired wait
// (timeout_release tells which wait), rdata holds the last read word;
// bus is the master side of the strobe bus.
module mem_test_bus_cycle
    import mem_test_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned SETUP_CYCLES   = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req,
    input  logic        rw,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ack,
    output logic        timeout,
    output logic        timeout_release,
    output logic [31:0] rdata,
    mem_test_master_if.master bus
);

    localparam int unsigned TmoBits =
        ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [TmoBits-1:0] TmoLast   = TmoBits'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]         SetupLast = 4'(SETUP_CYCLES - 1);

    bus_state_e         st_q, st_d;
    logic [31:0]        addr_q, wdata_q, rdata_q;
    logic               rwn_q;
    logic [3:0]         setup_cnt_q;
    logic [TmoBits-1:0] tcnt_q;
    logic               tmo_hit;

    assign tmo_hit = (tcnt_q == TmoLast);
    assign rdata   = rdata_q;

    always_ff @(posedge clk) begin
        if (!reset_n) st_q <= BsIdle;
        else          st_q <= st_d;
    end

    // DTACK is checked before the timeout, so an ack on the last cycle wins.
    always_comb begin
        st_d = st_q;
        unique case (st_q)
            BsIdle:    if (req) st_d = BsSetup;
            BsSetup:   if (setup_cnt_q == SetupLast) st_d = BsStrobe;
            BsStrobe: begin
                if (bus.DTACK)   st_d = BsRelease;
                else if (tmo_hit) st_d = BsIdle;
            end
            BsRelease: if (!bus.DTACK || tmo_hit) st_d = BsIdle;
            default:   st_d = BsIdle;
        endcase
    end

    always_comb begin
        ack             = (st_q == BsRelease) && !bus.DTACK;
        timeout         = ((st_q == BsStrobe) && !bus.DTACK && tmo_hit) ||
                          ((st_q == BsRelease) && bus.DTACK && tmo_hit);
        timeout_release = (st_q == BsRelease);
        bus.ASn         = (st_q != BsStrobe);
        bus.DBENn       = (st_q != BsStrobe);
        bus.UDS         = (st_q == BsStrobe);
        bus.LDS         = (st_q == BsStrobe);
        bus.UDS2        = (st_q == BsStrobe);
        bus.LDS2        = (st_q == BsStrobe);
        bus.RWn         = (st_q == BsIdle) ? 1'b1 : rwn_q;
        bus.ADR_OUT     = addr_q;
        bus.DATA_OUT    = wdata_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rwn_q       <= 1'b1;
            setup_cnt_q <= '0;
            tcnt_q      <= '0;
        end else begin
            if (st_q == BsIdle && req) begin
                addr_q      <= addr;
                rwn_q       <= rw;
                setup_cnt_q <= '0;
                if (!rw) wdata_q <= wdata;
            end
            if (st_q == BsSetup) setup_cnt_q <= setup_cnt_q + 4'd1;
            // Restart the timeout on every state change (entry to STROBE/RELEASE).
            if (st_q != st_d) tcnt_q <= '0;
            else if (st_q == BsStrobe || st_q == BsRelease) tcnt_q <= tcnt_q + 1'b1;
            if (st_q == BsStrobe && bus.DTACK && rwn_q) rdata_q <= bus.DATA_IN;
        end
    end

endmodule

// File: rtl/mem_test_master.sv
// Memory bring-up bus initiator: writes NUM_WORDS pattern words from
// BASE_ADDR, reads them back, compares, then issues one signature write
// ({00aa,0000} on pass, {00ff,err_code} on fail).
// Ports: clk, reset_n (sync, active low), start pulse; bus (master side of
// the strobe bus); busy, sticky done, pass and err_code status.
module mem_test_master
    import mem_test_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_1000,
    parameter int unsigned NUM_WORDS      = 64,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned SETUP_CYCLES   = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    mem_test_master_if.master bus,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_code
);

    localparam logic [15:0] LastIdx = 16'(NUM_WORDS - 1);

    top_state_e  st_q, st_d;
    phase_e      phase_q;
    logic [15:0] idx_q, err_q;
    logic        done_q, pass_q;

    logic        req, req_rw, bus_ack, bus_timeout, bus_tmo_rel;
    logic [31:0] req_addr, req_wdata, rdata;
    logic        last, mismatch;

    assign last     = (idx_q == LastIdx);
    assign mismatch = (rdata != pattern(idx_q));
    assign done     = done_q;
    assign pass     = pass_q;
    assign err_code = err_q;

    mem_test_bus_cycle #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SETUP_CYCLES   (SETUP_CYCLES)
    ) u_bus_cycle (
        .clk             (clk),
        .reset_n         (reset_n),
        .req             (req),
        .rw              (req_rw),
        .addr            (req_addr),
        .wdata           (req_wdata),
        .ack             (bus_ack),
        .timeout         (bus_timeout),
        .timeout_release (bus_tmo_rel),
        .rdata           (rdata),
        .bus             (bus)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) st_q <= StIdle;
        else          st_q <= st_d;
    end

    always_comb begin
        st_d = st_q;
        unique case (st_q)
            StIdle:  if (start) st_d = StIssue;
            StIssue: st_d = StWait;
            StWait: begin
                if (bus_timeout)  st_d = StSigIssue;
                else if (bus_ack) st_d = (phase_q == PhRead) ? StCheck : StIssue;
            end
            StCheck:    st_d = (mismatch || last) ? StSigIssue : StIssue;
            StSigIssue: st_d = StSigWait;
            // Signature cycle result is ignored: a timeout just ends the test.
            StSigWait:  if (bus_ack || bus_timeout) st_d = StDone;
            StDone:     st_d = StIdle;
            default:    st_d = StIdle;
        endcase
    end

    always_comb begin
        req  = (st_q == StIssue) || (st_q == StSigIssue);
        busy = (st_q != StIdle) && (st_q != StDone);
        if (st_q == StSigIssue || st_q == StSigWait) begin
            req_rw    = 1'b0;
            req_addr  = (err_q == 16'h0) ? {SIG_PASS, 16'h0000} : {SIG_FAIL, err_q};
            req_wdata = '0;
        end else begin
            req_rw    = (phase_q == PhRead);
            req_addr  = BASE_ADDR + {14'd0, idx_q, 2'b00};
            req_wdata = pattern(idx_q);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            phase_q <= PhWrite;
            idx_q   <= '0;
            err_q   <= '0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            if (st_q == StIdle && start) begin
                phase_q <= PhWrite;
                idx_q   <= '0;
                err_q   <= '0;
                done_q  <= 1'b0;
                pass_q  <= 1'b0;
            end
            if (st_q == StWait && bus_timeout) begin
                if (bus_tmo_rel)            err_q <= ERR_REL_TIMEOUT;
                else if (phase_q == PhRead) err_q <= ERR_RD_TIMEOUT;
                else                        err_q <= ERR_WR_TIMEOUT;
            end else if (st_q == StWait && bus_ack && phase_q == PhWrite) begin
                if (last) begin
                    phase_q <= PhRead;
                    idx_q   <= '0;
                end else begin
                    idx_q <= idx_q + 16'd1;
                end
            end
            if (st_q == StCheck) begin
                if (mismatch)   err_q <= ERR_MISMATCH_BASE | {1'b0, idx_q[14:0]};
                else if (!last) idx_q <= idx_q + 16'd1;
            end
            if (st_q == StSigWait && (bus_ack || bus_timeout)) begin
                done_q <= 1'b1;
                pass_q <= (err_q == 16'h0);
            end
        end
    end

endmodule

// File: tb/tb_mem_test_master.sv
module tb_mem_test_master;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int NW  = 4;
    localparam int TMO = 10;

    logic        clk = 1'b0;
    logic        reset_n, start;
    logic        busy, done, pass;
    logic [15:0] err_code;

    mem_test_master_if bus();

    mem_test_master #(
        .BASE_ADDR      (BASE),
        .NUM_WORDS      (NW),
        .TIMEOUT_CYCLES (TMO),
        .SETUP_CYCLES   (1)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .bus      (bus),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_code (err_code)
    );

    always #5 clk = ~clk;

    // Responder configuration, written only by the test sequence.
    int dly       = 2;
    bit never_ack = 1'b0;
    bit stuck     = 1'b0;
    int flip      = -1;

    // Responder state and transaction log, written only by the responder.
    int          n_tx = 0;
    int          low_cnt = 0;
    bit          acked_once = 1'b0;
    logic [31:0] mem [0:3];
    logic [31:0] tx_addr [0:127];
    logic [31:0] tx_data [0:127];
    logic        tx_rwn  [0:127];
    int          tx_low  [0:127];

    int total = 0;
    int bad   = 0;

    // Bridge model: acks after dly low-strobe cycles, drops DTACK once ASn rises.
    initial begin
        bus.DTACK   = 1'b0;
        bus.DATA_IN = '0;
        for (int k = 0; k < 4; k++) mem[k] = '0;
        forever begin
            @(negedge clk);
            if (bus.ASn == 1'b0) begin
                low_cnt++;
                if (low_cnt == 1 && n_tx < 128) begin
                    tx_addr[n_tx] = bus.ADR_OUT;
                    tx_data[n_tx] = bus.DATA_OUT;
                    tx_rwn[n_tx]  = bus.RWn;
                    n_tx++;
                end
                if (n_tx > 0) tx_low[n_tx-1] = low_cnt;
                if (!never_ack && !bus.DTACK && low_cnt >= dly) begin
                    automatic logic [31:0] off = bus.ADR_OUT - BASE;
                    automatic int w = int'(off[3:2]);
                    bus.DTACK  = 1'b1;
                    acked_once = 1'b1;
                    if (bus.RWn) bus.DATA_IN = mem[w] ^ ((w == flip) ? 32'h1 : 32'h0);
                    else         mem[w] = bus.DATA_OUT;
                end
            end else begin
                low_cnt = 0;
                if (!stuck) begin
                    bus.DTACK  = 1'b0;
                    acked_once = 1'b0;
                end else if (!acked_once) begin
                    bus.DTACK = 1'b0;
                end
            end
        end
    end

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rwn;
    } vec_t;

    vec_t vecs [0:8];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int c = 0;
        while (!done && c < 3000) begin
            @(negedge clk);
            c++;
        end
        check({nm, "_done"}, {31'd0, done}, 32'd1);
    endtask

    task automatic cmp_table(input string tag, input int base);
        check({tag, "_ntx"}, n_tx - base, 32'd9);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("%s_addr%0d", tag, i), tx_addr[base+i], vecs[i].addr);
            check($sformatf("%s_rwn%0d", tag, i), {31'd0, tx_rwn[base+i]},
                  {31'd0, vecs[i].rwn});
            if (!vecs[i].rwn)
                check($sformatf("%s_data%0d", tag, i), tx_data[base+i], vecs[i].data);
        end
    endtask

    initial begin
        int base;
        int c;

        vecs[0] = '{32'h0000_1000, 32'hffff_0000, 1'b0};
        vecs[1] = '{32'h0000_1004, 32'hfffe_0001, 1'b0};
        vecs[2] = '{32'h0000_1008, 32'hfffd_0002, 1'b0};
        vecs[3] = '{32'h0000_100c, 32'hfffc_0003, 1'b0};
        vecs[4] = '{32'h0000_1000, 32'h0, 1'b1};
        vecs[5] = '{32'h0000_1004, 32'h0, 1'b1};
        vecs[6] = '{32'h0000_1008, 32'h0, 1'b1};
        vecs[7] = '{32'h0000_100c, 32'h0, 1'b1};
        vecs[8] = '{32'h00aa_0000, 32'h0, 1'b0};

        reset_n = 1'b0;
        start   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_bus", {bus.ASn, bus.DBENn, bus.RWn, bus.UDS, bus.LDS, bus.UDS2, bus.LDS2},
              32'b1110000);
        check("rst_adr", bus.ADR_OUT, 32'h0);
        check("rst_dat", bus.DATA_OUT, 32'h0);
        check("rst_stat", {busy, done, pass, err_code}, 32'h0);
        @(negedge clk) reset_n = 1'b1;

        // Normal run, 2-cycle DTACK.
        base = n_tx;
        pulse_start();
        check("run_busy", {busy, done}, 32'b10);
        wait_done("norm");
        cmp_table("norm", base);
        check("norm_low", tx_low[base], 32'd2);
        check("norm_stat", {busy, pass, err_code}, {16'd0, 16'h0}  | 32'h0001_0000);

        // Read of word 2 returns bit 0 flipped.
        flip = 2;
        base = n_tx;
        pulse_start();
        wait_done("flip");
        flip = -1;
        check("flip_ntx", n_tx - base, 32'd8);
        check("flip_sig", tx_addr[base+7], 32'h00ff_8002);
        check("flip_err", {16'd0, err_code}, 32'h8002);
        check("flip_pass", {31'd0, pass}, 32'd0);

        // DTACK never arrives.
        never_ack = 1'b1;
        base = n_tx;
        pulse_start();
        wait_done("nack");
        never_ack = 1'b0;
        check("nack_low", tx_low[base], 32'd10);
        check("nack_ntx", n_tx - base, 32'd2);
        check("nack_sig", tx_addr[base+1], 32'h00ff_0001);
        check("nack_err", {16'd0, err_code}, 32'h0001);
        check("nack_pass", {31'd0, pass}, 32'd0);

        // DTACK stuck high after the first ack.
        stuck = 1'b1;
        base = n_tx;
        pulse_start();
        wait_done("stk");
        stuck = 1'b0;
        repeat (3) @(negedge clk);
        check("stk_err", {16'd0, err_code}, 32'h0003);
        check("stk_sig", tx_addr[base+1], 32'h00ff_0003);
        check("stk_dtack", {31'd0, bus.DTACK}, 32'd0);

        // Reset during STROBE of word 1.
        dly  = 5;
        base = n_tx;
        pulse_start();
        c = 0;
        while (n_tx < base + 2 && c < 500) begin
            @(negedge clk);
            c++;
        end
        check("rstm_reach", {31'd0, bus.ASn}, 32'd0);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check("rstm_asn", {bus.ASn, busy}, 32'b10);
        @(negedge clk) reset_n = 1'b1;
        dly  = 2;
        repeat (2) @(negedge clk);
        base = n_tx;
        pulse_start();
        wait_done("rerun");
        cmp_table("rerun", base);
        check("rerun_pass", {pass, err_code}, 32'h1_0000);

        // Ack on the exact timeout cycle, plus a stray start while busy.
        dly  = TMO;
        base = n_tx;
        pulse_start();
        repeat (30) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_done("edge");
        cmp_table("edge", base);
        check("edge_low", tx_low[base], 32'd10);
        check("edge_pass", {pass, err_code}, 32'h1_0000);
        repeat (10) @(negedge clk);
        check("edge_sticky", {31'd0, done}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
